// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// mips_multicycle_ctrl : multi-cycle MIPS32 control FSM with req/ready memory
// Rev 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int EXC_ON_OVF  = 1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [3:0] alu_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exception,
  output logic [1:0] exc_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_R   = 4'd5,
    S_WB_I   = 4'd6,
    S_MEMADR = 4'd7,
    S_MEMRD  = 4'd8,
    S_MEMWR  = 4'd9,
    S_MEMWB  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_EXC    = 4'd13
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_XORI  = 6'b001110;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  localparam logic [5:0] c_FN_ADD   = 6'b100000;
  localparam logic [5:0] c_FN_SUB   = 6'b100010;

  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_SLT  = 4'b0111;
  localparam logic [3:0] c_ALU_SLL  = 4'b1000;
  localparam logic [3:0] c_ALU_SRL  = 4'b1001;
  localparam logic [3:0] c_ALU_XOR  = 4'b1010;
  localparam logic [3:0] c_ALU_SRA  = 4'b1011;
  localparam logic [3:0] c_ALU_NOR  = 4'b1100;

  localparam logic [1:0] c_CAUSE_ILL = 2'b01;
  localparam logic [1:0] c_CAUSE_OVF = 2'b10;
  localparam logic [1:0] c_CAUSE_TMO = 2'b11;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       w_cause;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_timeout;
  logic             w_funct_legal;
  logic             w_branch_take;
  logic             w_ovf_trap_r;
  logic             w_ovf_trap_i;

  logic       r_mem_req;
  logic       r_mem_we;
  logic       r_pc_write;
  logic [1:0] r_pc_src;
  logic       r_alu_src_a;
  logic [1:0] r_alu_src_b;
  logic       r_imm_zext;
  logic [3:0] r_alu_control;
  logic       r_reg_write;
  logic       r_reg_dst;
  logic       r_mem_to_reg;
  logic       r_exception;
  logic [1:0] r_exc_cause;

  function automatic logic [3:0] alu_for_funct(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001: alu_for_funct = c_ALU_ADD;
      6'b100010, 6'b100011: alu_for_funct = c_ALU_SUB;
      6'b100100:            alu_for_funct = c_ALU_AND;
      6'b100101:            alu_for_funct = c_ALU_OR;
      6'b100110:            alu_for_funct = c_ALU_XOR;
      6'b100111:            alu_for_funct = c_ALU_NOR;
      6'b101010:            alu_for_funct = c_ALU_SLT;
      6'b000000:            alu_for_funct = c_ALU_SLL;
      6'b000010:            alu_for_funct = c_ALU_SRL;
      6'b000011:            alu_for_funct = c_ALU_SRA;
      default:              alu_for_funct = c_ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] alu_for_opcode(input logic [5:0] op);
    case (op)
      c_OP_SLTI: alu_for_opcode = c_ALU_SLT;
      c_OP_ANDI: alu_for_opcode = c_ALU_AND;
      c_OP_ORI:  alu_for_opcode = c_ALU_OR;
      c_OP_XORI: alu_for_opcode = c_ALU_XOR;
      default:   alu_for_opcode = c_ALU_ADD;
    endcase
  endfunction

  always_comb begin
    w_funct_legal = 1'b0;
    case (funct)
      6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011:
        w_funct_legal = 1'b1;
      default: w_funct_legal = 1'b0;
    endcase
  end

  // Only the trapping add/sub/addi forms are checked; the unsigned variants never trap.
  assign w_ovf_trap_r  = (EXC_ON_OVF != 0) && overflow && ((funct == c_FN_ADD) || (funct == c_FN_SUB));
  assign w_ovf_trap_i  = (EXC_ON_OVF != 0) && overflow && (opcode == c_OP_ADDI);
  assign w_timeout     = (MEM_TIMEOUT != 0) && (r_wait_cnt == c_WAIT_LAST);
  assign w_branch_take = ((opcode == c_OP_BEQ) && zero) || ((opcode == c_OP_BNE) && !zero);

  always_comb begin
    w_next  = r_state;
    w_cause = r_exc_cause;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next  = S_EXC;
          w_cause = c_CAUSE_TMO;
        end
      end
      S_DECODE: begin
        case (opcode)
          c_OP_RTYPE: begin
            if (w_funct_legal) begin
              w_next = S_EXEC_R;
            end else begin
              w_next  = S_EXC;
              w_cause = c_CAUSE_ILL;
            end
          end
          c_OP_LW, c_OP_SW:   w_next = S_MEMADR;
          c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
          c_OP_J:             w_next = S_JUMP;
          c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_ANDI, c_OP_ORI, c_OP_XORI:
                              w_next = S_EXEC_I;
          default: begin
            w_next  = S_EXC;
            w_cause = c_CAUSE_ILL;
          end
        endcase
      end
      S_EXEC_R: begin
        if (w_ovf_trap_r) begin
          w_next  = S_EXC;
          w_cause = c_CAUSE_OVF;
        end else begin
          w_next = S_WB_R;
        end
      end
      S_EXEC_I: begin
        if (w_ovf_trap_i) begin
          w_next  = S_EXC;
          w_cause = c_CAUSE_OVF;
        end else begin
          w_next = S_WB_I;
        end
      end
      S_MEMADR: w_next = (opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_next  = S_EXC;
          w_cause = c_CAUSE_TMO;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next  = S_EXC;
          w_cause = c_CAUSE_TMO;
        end
      end
      S_WB_R, S_WB_I, S_MEMWB, S_BRANCH, S_JUMP, S_EXC: w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs are decoded from the next state so they leave the flops
  // aligned with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_pc_write    <= 1'b0;
      r_pc_src      <= 2'b00;
      r_alu_src_a   <= 1'b0;
      r_alu_src_b   <= 2'b00;
      r_imm_zext    <= 1'b0;
      r_alu_control <= 4'b0000;
      r_reg_write   <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_exception   <= 1'b0;
      r_exc_cause   <= 2'b00;
    end else begin
      r_state     <= w_next;
      r_exc_cause <= w_cause;
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_pc_write    <= 1'b0;
      r_pc_src      <= 2'b00;
      r_alu_src_a   <= 1'b0;
      r_alu_src_b   <= 2'b00;
      r_imm_zext    <= 1'b0;
      r_alu_control <= 4'b0000;
      r_reg_write   <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_exception   <= 1'b0;
      case (w_next)
        S_FETCH: begin
          r_mem_req     <= 1'b1;
          r_alu_control <= c_ALU_ADD;
          r_alu_src_b   <= 2'b01;
        end
        S_DECODE: begin
          r_alu_control <= c_ALU_ADD;
          r_alu_src_b   <= 2'b11;
        end
        S_EXEC_R: begin
          r_alu_src_a   <= 1'b1;
          r_alu_control <= alu_for_funct(funct);
        end
        S_EXEC_I: begin
          r_alu_src_a   <= 1'b1;
          r_alu_src_b   <= 2'b10;
          r_alu_control <= alu_for_opcode(opcode);
          r_imm_zext    <= (opcode == c_OP_ANDI) || (opcode == c_OP_ORI) || (opcode == c_OP_XORI);
        end
        S_WB_R: begin
          r_reg_write <= 1'b1;
          r_reg_dst   <= 1'b1;
        end
        S_WB_I: r_reg_write <= 1'b1;
        S_MEMADR: begin
          r_alu_control <= c_ALU_ADD;
          r_alu_src_a   <= 1'b1;
          r_alu_src_b   <= 2'b10;
        end
        S_MEMRD: r_mem_req <= 1'b1;
        S_MEMWR: begin
          r_mem_req <= 1'b1;
          r_mem_we  <= 1'b1;
        end
        S_MEMWB: begin
          r_reg_write  <= 1'b1;
          r_mem_to_reg <= 1'b1;
        end
        S_BRANCH: begin
          r_alu_control <= c_ALU_SUB;
          r_alu_src_a   <= 1'b1;
          r_pc_src      <= 2'b01;
        end
        S_JUMP: begin
          r_pc_write <= 1'b1;
          r_pc_src   <= 2'b10;
        end
        S_EXC: begin
          r_exception <= 1'b1;
          r_pc_write  <= 1'b1;
          r_pc_src    <= 2'b11;
        end
        default: ;
      endcase
    end
  end

  // Fetch completion and branch resolution depend on this cycle's handshake/flag.
  assign ir_write    = (r_state == S_FETCH) && mem_ready;
  assign pc_write    = r_pc_write || ir_write || ((r_state == S_BRANCH) && w_branch_take);
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign pc_src      = r_pc_src;
  assign alu_src_a   = r_alu_src_a;
  assign alu_src_b   = r_alu_src_b;
  assign imm_zext    = r_imm_zext;
  assign alu_control = r_alu_control;
  assign reg_write   = r_reg_write;
  assign reg_dst     = r_reg_dst;
  assign mem_to_reg  = r_mem_to_reg;
  assign exception   = r_exception;
  assign exc_cause   = r_exc_cause;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS32 control FSM. It is the initiator side of the datapath ALU contract: it decodes instruction opcode/funct and drives `alu_control` and the operand selects.
- It samples the ALU `zero`/`overflow` flags back for branch resolution and overflow traps.
- It sequences instruction fetch, memory access and register writeback, with a req/ready memory handshake.

Parameters:
- EXC_ON_OVF, 1, 1 means add/sub/addi overflow traps and writeback is suppressed; 0 means overflow is ignored.
- MEM_TIMEOUT, 0, maximum wait cycles per memory access; 0 disables the timeout.

Ports:
- clk input 1 system clock, rising edge
- rst input 1 asynchronous active-high reset
- opcode input 6 IR[31:26], valid from DECODE onward
- funct input 6 IR[5:0]
- zero input 1 ALU Zero flag
- overflow input 1 ALU Overflow flag
- mem_ready input 1 memory completes the current request this cycle
- mem_req output 1 memory request, held until mem_ready
- mem_we output 1 write request (sw)
- ir_write output 1 load IR from memory data
- pc_write output 1 PC update enable
- pc_src output 2 PC source: 00 ALU result, 01 ALUOut register, 10 jump target, 11 exception vector
- alu_src_a output 1 ALU A operand: 0 PC, 1 register A
- alu_src_b output 2 ALU B operand: 00 register B, 01 constant 4, 10 extended imm, 11 sign-ext imm<<2
- imm_zext output 1 zero-extend imm (andi/ori/xori), otherwise sign-extend
- alu_control output 4 ALU code: AND 0000, OR 0001, NOR 1100, XOR 1010, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1011
- reg_write output 1 register file write enable
- reg_dst output 1 destination: 1 rd, 0 rt
- mem_to_reg output 1 writeback source: 1 MDR, 0 ALUOut
- exception output 1 one-cycle trap pulse
- exc_cause output 2 trap cause: 01 illegal, 10 overflow, 11 memory timeout; held until next trap or reset
- state output 4 current state, for debug

Behaviour:
- **Outputs.** All outputs are Moore-decoded from the state register, except `pc_write` in BRANCH.
- **Reset.**
  - `rst` forces state IDLE asynchronously and clears `exc_cause`.
  - In IDLE every output is 0 and `state` is 0.
  - IDLE goes to FETCH on the first clock after `rst` is deasserted.
- **States.**
  - FETCH: `mem_req`=1, ALU ADD with `alu_src_a`=0 and `alu_src_b`=01. Stays in FETCH while `mem_ready`=0. When `mem_ready`=1 it asserts `ir_write`, `pc_write` and `pc_src`=00, then goes to DECODE.
  - DECODE: ALU ADD with `alu_src_a`=0 and `alu_src_b`=11 (branch target into ALUOut). Next state by opcode:
    - 000000 goes to EXEC_R if funct is legal, else EXC (illegal).
    - 100011/101011 go to MEMADR.
    - 000100/000101 go to BRANCH.
    - 000010 goes to JUMP.
    - 001000/001001/001010/001100/001101/001110 go to EXEC_I.
    - Any other opcode goes to EXC (illegal).
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_control` per funct:
    - 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
    - 000000 SLL, 000010 SRL, 000011 SRA.
    - Goes to WB_R. If EXC_ON_OVF=1, funct is 100000 or 100010, and `overflow`=1, it goes to EXC (overflow) instead.
  - EXEC_I: `alu_src_a`=1, `alu_src_b`=10.
    - Opcode mapping: addi/addiu ADD, slti SLT, andi AND, ori OR, xori XOR.
    - `imm_zext`=1 for andi/ori/xori.
    - addi overflow goes to EXC under the same rule as EXEC_R; otherwise goes to WB_I.
  - WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, then FETCH.
  - WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, then FETCH.
  - MEMADR: ALU ADD with `alu_src_a`=1 and `alu_src_b`=10. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: `mem_req`=1, `mem_we`=0. Waits for `mem_ready`, then goes to MEMWB.
  - MEMWR: `mem_req`=1, `mem_we`=1. Waits for `mem_ready`, then goes to FETCH.
  - MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, then FETCH.
  - BRANCH: ALU SUB with `alu_src_a`=1 and `alu_src_b`=00, `pc_src`=01. `pc_write` = (beq & `zero`) | (bne & ~`zero`). Then FETCH.
  - JUMP: `pc_write`=1, `pc_src`=10, then FETCH.
  - EXC: `exception`=1, `pc_write`=1, `pc_src`=11, `exc_cause` latched, then FETCH. `reg_write` is never asserted on a trapping instruction.
- **Latency with `mem_ready` in the first cycle.**
  - R-type, I-ALU and sw: 4 cycles.
  - lw: 5 cycles.
  - beq, bne and j: 3 cycles.
- **Memory handshake.**
  - `mem_req`, `mem_we` and the address select stay stable until `mem_ready` is seen.
  - `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
  - A wait counter clears on entry to each memory state. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without `mem_ready`, the FSM goes to EXC (cause 11).
  - If `mem_ready` arrives on the same cycle the counter reaches MEM_TIMEOUT, `mem_ready` wins.
- **Reset mid-operation.** `mem_req` and `reg_write` drop in the same cycle `rst` asserts (asynchronous). No partial writeback occurs.

Test Plan:
1. Reset release, `mem_ready`=1 constantly, IR=add (opcode 0, funct 100000), `overflow`=0 → states IDLE, FETCH, DECODE, EXEC_R (`alu_control`=0010), WB_R (`reg_write`=1, `reg_dst`=1), FETCH.
2. lw with `mem_ready` delayed 3 cycles in MEMRD, MEM_TIMEOUT=0 → `mem_req` held 4 cycles, then MEMWB with `mem_to_reg`=1.
3. beq with `zero`=1 → `pc_write`=1, `pc_src`=01 in BRANCH. Repeat with bne and `zero`=1 → `pc_write`=0, then FETCH.
4. addi with `overflow`=1, EXC_ON_OVF=1 → EXC, `exception` pulse of 1 cycle, `exc_cause`=10, `reg_write` never asserted. Repeat with addiu → WB_I, no trap.
5. opcode 111111, then R-type funct 111111 → EXC from DECODE, `exc_cause`=01.
6. MEM_TIMEOUT=4, `mem_ready` never asserted in FETCH → EXC after 4 wait cycles, `exc_cause`=11. Assert `rst` mid-MEMWR → `mem_req`=0 immediately, `state`=IDLE.
